// File: rtl/wait_state_memory_if.sv
// ============================================================================
// Module      : wait_state_memory_if
// Description : Request/acknowledge memory bus between requester and responder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wait_state_memory_if;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, rw, size, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, rw, size, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

`default_nettype wire

// File: rtl/wait_state_memory.sv
// ============================================================================
// Module      : wait_state_memory
// Description : Big-endian byte memory responder with fixed wait states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_state_memory #(
  parameter int DEPTH = 128,
  parameter int WAIT  = 2
) (
  input  wire logic            clock,
  input  wire logic            reset,
  wait_state_memory_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [7:0]  mem_q [DEPTH];

  logic [2:0]    nbytes;
  logic [32:0]   end_addr;
  logic          access_err;
  logic          commit;
  logic [31:0]   read_val;
  logic [AW-1:0] idx     [4];
  logic [7:0]    wr_byte [4];
  logic [3:0]    wr_en;

  // Access decode works entirely from the latched request fields.
  always_comb begin
    case (size_q)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr   = {1'b0, addr_q} + {30'd0, nbytes} - 33'd1;
    access_err = (size_q == 2'd3)
              || (size_q == 2'd1 && addr_q[0])
              || (size_q == 2'd2 && addr_q[1:0] != 2'd0)
              || (end_addr >= 33'(DEPTH));
    commit     = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    for (int i = 0; i < 4; i++) begin
      idx[i]     = addr_q[AW-1:0] + AW'(i);
      wr_byte[i] = wdata_q[31-8*i -: 8];
    end

    case (size_q)
      2'd0: begin
        wr_en      = 4'b0001;
        wr_byte[0] = wdata_q[7:0];
        read_val   = {24'd0, mem_q[idx[0]]};
      end
      2'd1: begin
        wr_en      = 4'b0011;
        wr_byte[0] = wdata_q[15:8];
        wr_byte[1] = wdata_q[7:0];
        read_val   = {16'd0, mem_q[idx[0]], mem_q[idx[1]]};
      end
      default: begin
        wr_en    = 4'b1111;
        read_val = {mem_q[idx[0]], mem_q[idx[1]], mem_q[idx[2]], mem_q[idx[3]]};
      end
    endcase

    if (!(commit && !rw_q && !access_err)) begin
      wr_en = 4'b0000;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          rw_d    = bus.rw;
          size_d  = bus.size;
          wdata_d = bus.wdata;
          cnt_d   = 4'(WAIT);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          err_d   = access_err;
          if (rw_q) begin
            rdata_d = access_err ? 32'd0 : read_val;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rw_q    <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage keeps its contents through reset; during reset state is IDLE so no lane is enabled.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem_q[idx[i]] <= wr_byte[i];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_wait_state_memory.sv
// ============================================================================
// Module      : tb_wait_state_memory
// Description : Directed vector bench for wait_state_memory (WAIT=2 and WAIT=0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wait_state_memory;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  wait_state_memory_if bus0 ();
  wait_state_memory_if bus1 ();

  wait_state_memory #(.DEPTH(128), .WAIT(2)) u_dut_w2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  wait_state_memory #(.DEPTH(128), .WAIT(0)) u_dut_w0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  typedef struct {
    logic        ack;
    logic        err;
    logic        busy;
    logic [31:0] rdata;
  } outs_t;

  vec_t vecs [28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rq, input logic rw, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      bus0.req = rq; bus0.rw = rw; bus0.size = sz; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus1.req = rq; bus1.rw = rw; bus1.size = sz; bus1.addr = a; bus1.wdata = wd;
    end
  endtask

  function automatic outs_t peek(input int sel);
    outs_t o;
    if (sel == 0) begin
      o.ack = bus0.ack; o.err = bus0.err; o.busy = bus0.busy; o.rdata = bus0.rdata;
    end else begin
      o.ack = bus1.ack; o.err = bus1.err; o.busy = bus1.busy; o.rdata = bus1.rdata;
    end
    return o;
  endfunction

  // One complete transaction: accept, measure ack latency, check response, check return to idle.
  task automatic do_access(input int sel, input int w, input vec_t v);
    outs_t o;
    int    n;
    bit    got;
    @(negedge clock);
    drive(sel, 1'b1, v.rw, v.size, v.addr, v.wdata);
    @(posedge clock); #1;
    o = peek(sel);
    check({v.name, "_busy"}, 32'(o.busy), 32'd1);
    // Scramble held fields: only the values latched at acceptance may matter.
    if (sel == 0) bus0.wdata = ~v.wdata; else bus1.wdata = ~v.wdata;
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clock); #1;
      n++;
      o = peek(sel);
      if (o.ack) got = 1;
    end
    drive(sel, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    if (!got) begin
      check({v.name, "_ack_timeout"}, 32'd0, 32'd1);
    end else begin
      check({v.name, "_latency"}, 32'(n), 32'(w + 1));
      check({v.name, "_err"}, 32'(o.err), 32'(v.err));
      check({v.name, "_rdata"}, o.rdata, v.rdata);
      @(posedge clock); #1;
      o = peek(sel);
      check({v.name, "_idle"}, {29'd0, o.ack, o.err, o.busy}, 32'd0);
    end
  endtask

  task automatic burst(input int sel, input int w, input logic [31:0] a, input logic [31:0] exp_rd,
                       input string name);
    int    t [4];
    int    e0;
    int    k;
    int    guard;
    outs_t o;
    @(negedge clock);
    drive(sel, 1'b1, 1'b1, 2'd2, a, 32'd0);
    @(posedge clock); #1;
    e0    = cyc;
    k     = 0;
    guard = 0;
    while (k < 4 && guard < 60) begin
      @(posedge clock); #1;
      guard++;
      o = peek(sel);
      if (o.ack) begin
        t[k] = cyc;
        k++;
      end
    end
    drive(sel, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    check({name, "_count"}, 32'(k), 32'd4);
    if (k == 4) begin
      check({name, "_first"}, 32'(t[0] - e0), 32'(w + 1));
      for (int i = 1; i < 4; i++) begin
        check({name, "_gap"}, 32'(t[i] - t[i-1]), 32'(w + 3));
      end
      check({name, "_rdata"}, o.rdata, exp_rd);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t o;
    int    seen;

    //          rw    size  addr           wdata          err   rdata          name
    vecs[0]  = '{1'b0, 2'd2, 32'h0000_000C, 32'h1322_1000, 1'b0, 32'h0000_0000, "wr_w_0c"};
    vecs[1]  = '{1'b1, 2'd2, 32'h0000_000C, 32'h0,         1'b0, 32'h1322_1000, "rd_w_0c"};
    vecs[2]  = '{1'b1, 2'd0, 32'h0000_000C, 32'h0,         1'b0, 32'h0000_0013, "rd_b_0c"};
    vecs[3]  = '{1'b1, 2'd0, 32'h0000_000D, 32'h0,         1'b0, 32'h0000_0022, "rd_b_0d"};
    vecs[4]  = '{1'b1, 2'd0, 32'h0000_000E, 32'h0,         1'b0, 32'h0000_0010, "rd_b_0e"};
    vecs[5]  = '{1'b1, 2'd0, 32'h0000_000F, 32'h0,         1'b0, 32'h0000_0000, "rd_b_0f"};
    vecs[6]  = '{1'b1, 2'd1, 32'h0000_000E, 32'h0,         1'b0, 32'h0000_1000, "rd_h_0e"};
    vecs[7]  = '{1'b0, 2'd0, 32'h0000_000D, 32'hFFFF_FFAB, 1'b0, 32'h0000_1000, "wr_b_0d"};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_000C, 32'h0,         1'b0, 32'h13AB_1000, "rd_w_merge"};
    vecs[9]  = '{1'b1, 2'd0, 32'h0000_000C, 32'h0,         1'b0, 32'h0000_0013, "rd_b_0c_b"};
    vecs[10] = '{1'b1, 2'd0, 32'h0000_000E, 32'h0,         1'b0, 32'h0000_0010, "rd_b_0e_b"};
    vecs[11] = '{1'b1, 2'd0, 32'h0000_000F, 32'h0,         1'b0, 32'h0000_0000, "rd_b_0f_b"};
    vecs[12] = '{1'b0, 2'd2, 32'h0000_007C, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, "wr_w_7c"};
    vecs[13] = '{1'b1, 2'd2, 32'h0000_007E, 32'h0,         1'b1, 32'h0000_0000, "err_rd_w_7e"};
    vecs[14] = '{1'b0, 2'd2, 32'h0000_0080, 32'h1234_5678, 1'b1, 32'h0000_0000, "err_wr_w_80"};
    vecs[15] = '{1'b1, 2'd2, 32'h0000_007C, 32'h0,         1'b0, 32'hCAFE_F00D, "rd_w_7c"};
    vecs[16] = '{1'b1, 2'd1, 32'h0000_000D, 32'h0,         1'b1, 32'h0000_0000, "err_rd_h_0d"};
    vecs[17] = '{1'b1, 2'd3, 32'h0000_000C, 32'h0,         1'b1, 32'h0000_0000, "err_rd_sz3"};
    vecs[18] = '{1'b0, 2'd3, 32'h0000_000C, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "err_wr_sz3"};
    vecs[19] = '{1'b1, 2'd2, 32'h0000_000C, 32'h0,         1'b0, 32'h13AB_1000, "rd_w_0c_kept"};
    vecs[20] = '{1'b0, 2'd1, 32'h0000_007E, 32'h0000_BEEF, 1'b0, 32'h13AB_1000, "wr_h_7e"};
    vecs[21] = '{1'b1, 2'd2, 32'h0000_007C, 32'h0,         1'b0, 32'hCAFE_BEEF, "rd_w_7c_b"};
    vecs[22] = '{1'b1, 2'd0, 32'h0000_007F, 32'h0,         1'b0, 32'h0000_00EF, "rd_b_last"};
    vecs[23] = '{1'b1, 2'd2, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000, "err_rd_wrap"};
    vecs[24] = '{1'b0, 2'd1, 32'h0000_007F, 32'h0000_1234, 1'b1, 32'h0000_0000, "err_wr_h_7f"};
    vecs[25] = '{1'b1, 2'd0, 32'h0000_007F, 32'h0,         1'b0, 32'h0000_00EF, "rd_b_last_b"};
    vecs[26] = '{1'b0, 2'd2, 32'h0000_0020, 32'h0000_0005, 1'b0, 32'h0000_00EF, "wr_w_20"};
    vecs[27] = '{1'b1, 2'd2, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0005, "rd_w_20"};

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    for (int s = 0; s < 2; s++) begin
      o = peek(s);
      check("reset_flags", {29'd0, o.ack, o.err, o.busy}, 32'd0);
      check("reset_rdata", o.rdata, 32'd0);
    end

    for (int i = 0; i < 28; i++) begin
      do_access(0, 2, vecs[i]);
    end

    // Reset asserted while a write to 0x20 is still waiting out its wait states.
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'hDEAD_BEEF);
    @(posedge clock);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    o = peek(0);
    check("rst_mid_flags", {29'd0, o.ack, o.err, o.busy}, 32'd0);
    check("rst_mid_rdata", o.rdata, 32'd0);
    drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clock); #1;
      o = peek(0);
      if (o.ack) seen++;
    end
    check("rst_no_ack", 32'(seen), 32'd0);
    do_access(0, 2, '{1'b1, 2'd2, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_0005, "rd_w_20_after_rst"});

    burst(0, 2, 32'h0000_0020, 32'h0000_0005, "burst_w2");

    do_access(1, 0, '{1'b0, 2'd2, 32'h0000_0010, 32'hA5A5_5A5A, 1'b0, 32'h0000_0000, "w0_wr_w_10"});
    do_access(1, 0, '{1'b1, 2'd1, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_5A5A, "w0_rd_h_12"});
    burst(1, 0, 32'h0000_0010, 32'hA5A5_5A5A, "burst_w0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
